// File: rtl/cdb_arbiter_pkg.sv
// Core-wide CDB definitions: tag/data widths, the reserved "no producer" label,
// and the packed broadcast triple snooped by the register file and stations.
package cdb_arbiter_pkg;

  localparam int LABEL_W = 5;
  localparam int DATA_W  = 32;

  localparam logic [LABEL_W-1:0] NO_LABEL = '0;

  typedef struct packed {
    logic               en;
    logic [LABEL_W-1:0] label;
    logic [DATA_W-1:0]  data;
  } bcast_t;

  // Width of an index into n requesters; at least one bit.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Request/grant/broadcast bundle between the functional units and the CDB arbiter.
// master = arbiter side; slave = requesters and snoopers.
interface cdb_arbiter_if #(
  parameter int NUM_SRC = 4
) ();
  import cdb_arbiter_pkg::*;

  logic [NUM_SRC-1:0]         req;
  logic [NUM_SRC*LABEL_W-1:0] req_label;
  logic [NUM_SRC*DATA_W-1:0]  req_data;
  logic [NUM_SRC-1:0]         grant;
  logic                       BCEN;
  logic [LABEL_W-1:0]         BClabel;
  logic [DATA_W-1:0]          BCdata;

  modport master (
    input  req, req_label, req_data,
    output grant, BCEN, BClabel, BCdata
  );

  modport slave (
    output req, req_label, req_data,
    input  grant, BCEN, BClabel, BCdata
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index scanning from ptr_i,
// wrapping modulo NUM_SRC; returns the one-hot grant and the winner index.
module rr_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int PTR_W   = ptr_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] elig_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] grant_o,
  output logic [PTR_W-1:0]   win_o,
  output logic               valid_o
);

  logic [PTR_W:0] idx;

  // Scan from the farthest offset down so the nearest eligible index wins last.
  always_comb begin
    grant_o = '0;
    win_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_i} + (PTR_W + 1)'(k);
      if (idx >= (PTR_W + 1)'(NUM_SRC)) begin
        idx = idx - (PTR_W + 1)'(NUM_SRC);
      end
      if (elig_i[idx]) begin
        win_o   = idx[PTR_W-1:0];
        valid_o = 1'b1;
      end
    end
    if (valid_o) begin
      grant_o[win_o] = 1'b1;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grant among NUM_SRC result holders and a
// registered BCEN/BClabel/BCdata broadcast. Define CDB_FLUSH_EN to add the flush input.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic          clk,
  input  logic          RST,
`ifdef CDB_FLUSH_EN
  input  logic          flush,
`endif
  cdb_arbiter_if.master cdb_io
);

  localparam int PTR_W = ptr_width(NUM_SRC);

  logic [LABEL_W-1:0] label_arr [NUM_SRC];
  logic [DATA_W-1:0]  data_arr  [NUM_SRC];
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] pick_grant;
  logic [PTR_W-1:0]   win;
  logic               win_valid;
  logic               suppress;

  bcast_t             bc_q, bc_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  // Label 0 means "no pending producer", so such requests are never eligible.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign label_arr[gi] = cdb_io.req_label[gi*LABEL_W +: LABEL_W];
    assign data_arr[gi]  = cdb_io.req_data[gi*DATA_W +: DATA_W];
    assign elig[gi]      = cdb_io.req[gi] && (label_arr[gi] != NO_LABEL);
  end

`ifdef CDB_FLUSH_EN
  assign suppress = RST | flush;
`else
  assign suppress = RST;
`endif

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .win_o   (win),
    .valid_o (win_valid)
  );

  assign cdb_io.grant = suppress ? '0 : pick_grant;

  // Idle cycles drop BCEN but keep the last tag/value on the bus.
  always_comb begin
    bc_d    = bc_q;
    bc_d.en = 1'b0;
    ptr_d   = ptr_q;
    if (!suppress && win_valid) begin
      bc_d.en    = 1'b1;
      bc_d.label = label_arr[win];
      bc_d.data  = data_arr[win];
      ptr_d      = (win == PTR_W'(NUM_SRC - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      bc_q  <= '0;
      ptr_q <= '0;
    end else begin
      bc_q  <= bc_d;
      ptr_q <= ptr_d;
    end
  end

  assign cdb_io.BCEN    = bc_q.en;
  assign cdb_io.BClabel = bc_q.label;
  assign cdb_io.BCdata  = bc_q.data;

endmodule
